// File: rtl/mv_pe_pkg.sv
// rtl/mv_pe_pkg.sv - shared state encoding, data width and BRAM word-map helpers
package mv_pe_pkg;

  localparam int DATA_W  = 32;
  localparam int STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LOAD_X = 3'd1;
  localparam state_t S_LOAD_W = 3'd2;
  localparam state_t S_CALC   = 3'd3;
  localparam state_t S_WRITE  = 3'd4;
  localparam state_t S_DONE   = 3'd5;

  localparam logic [3:0] WE_ALL = 4'hF;

  // Word indices into the BRAM: x first, then the weight rows, then the results.
  function automatic logic [DATA_W-1:0] x_base();
    return 32'd0;
  endfunction

  function automatic logic [DATA_W-1:0] w_base(input int vsize, input int row);
    return 32'(vsize * (1 + row));
  endfunction

  function automatic logic [DATA_W-1:0] y_base(input int vsize, input int npe);
    return 32'(vsize * (npe + 1));
  endfunction

endpackage

// File: rtl/mv_pe_con_if.sv
// rtl/mv_pe_con_if.sv - job control and single-port BRAM signals of the controller
interface mv_pe_con_if;
  logic        start;
  logic        relu_en;
  logic        busy;
  logic        done;
  logic [31:0] BRAM_ADDR;
  logic [31:0] BRAM_WRDATA;
  logic [3:0]  BRAM_WE;
  logic [31:0] BRAM_RDDATA;

  modport master (
    input  start, relu_en, BRAM_RDDATA,
    output busy, done, BRAM_ADDR, BRAM_WRDATA, BRAM_WE
  );

  modport slave (
    output start, relu_en, BRAM_RDDATA,
    input  busy, done, BRAM_ADDR, BRAM_WRDATA, BRAM_WE
  );
endinterface

// File: rtl/mv_pe_con_mac_lane.sv
// rtl/mv_pe_con_mac_lane.sv - one MAC lane: private weight row buffer plus wrapping accumulator
module mac_lane
  import mv_pe_pkg::*;
#(
  parameter int VECTOR_SIZE = 16,
  parameter int L_RAM_SIZE  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [L_RAM_SIZE-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [L_RAM_SIZE-1:0] rd_addr,
  input  logic [DATA_W-1:0]     x_data,
  input  logic                  acc_clr,
  input  logic                  acc_en,
  output logic [DATA_W-1:0]     acc
);

  logic [DATA_W-1:0] mem [VECTOR_SIZE];
  logic [DATA_W-1:0] rd_data;

  // Registered read keeps this mappable onto a block RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

  // Low 32 bits of the product are identical for signed and unsigned operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= acc + rd_data * x_data;
    end
  end

endmodule

// File: rtl/mv_pe_con.sv
// rtl/mv_pe_con.sv - matrix-vector multiply controller sequencing loads, MAC and result writes over one BRAM port
module mv_pe_con
  import mv_pe_pkg::*;
#(
  parameter int VECTOR_SIZE = 16,
  parameter int L_RAM_SIZE  = 4,
  parameter int NUM_PE      = 4
) (
  input logic         aclk,
  input logic         areset,
  mv_pe_con_if.master bus
);

  localparam int NV = NUM_PE * VECTOR_SIZE;
  localparam int CW = $clog2(NV + 1);

  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] X_LAST = CW'(VECTOR_SIZE);
  localparam logic [CW-1:0] W_LAST = CW'(NV);
  localparam logic [CW-1:0] C_LAST = CW'(VECTOR_SIZE);
  localparam logic [CW-1:0] Y_LAST = CW'(NUM_PE - 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     idx;
  logic              relu_q;
  logic [DATA_W-1:0] x_buf [VECTOR_SIZE];
  logic [DATA_W-1:0] x_rd;
  logic [DATA_W-1:0] acc_all [NUM_PE];
  logic [DATA_W-1:0] acc_sel;
  logic [DATA_W-1:0] word_idx;
  logic              load_w_valid;
  logic              acc_clr;
  logic              acc_en;

  // Read data lags its address by one cycle, so capture uses the previous count.
  assign idx          = cnt - ONE;
  assign load_w_valid = (state == S_LOAD_W) && (cnt != '0);
  assign acc_clr      = (state == S_LOAD_W) && (cnt == W_LAST);
  assign acc_en       = (state == S_CALC) && (cnt != '0);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      relu_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state  <= S_LOAD_X;
            cnt    <= '0;
            relu_q <= bus.relu_en;
          end
        end
        S_LOAD_X: begin
          if (cnt == X_LAST) begin
            state <= S_LOAD_W;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        S_LOAD_W: begin
          if (cnt == W_LAST) begin
            state <= S_CALC;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        S_CALC: begin
          if (cnt == C_LAST) begin
            state <= S_WRITE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        S_WRITE: begin
          if (cnt == Y_LAST) begin
            state <= S_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if ((state == S_LOAD_X) && (cnt != '0)) begin
      x_buf[idx[L_RAM_SIZE-1:0]] <= bus.BRAM_RDDATA;
    end
    x_rd <= x_buf[cnt[L_RAM_SIZE-1:0]];
  end

  // Row-major weight stream: the upper bits of the word offset select the lane.
  for (genvar g = 0; g < NUM_PE; g++) begin : g_lane
    logic lane_we;
    assign lane_we = load_w_valid && ((idx >> L_RAM_SIZE) == CW'(g));

    mac_lane #(
      .VECTOR_SIZE (VECTOR_SIZE),
      .L_RAM_SIZE  (L_RAM_SIZE)
    ) u_lane (
      .clk     (aclk),
      .rst     (areset),
      .wr_en   (lane_we),
      .wr_addr (idx[L_RAM_SIZE-1:0]),
      .wr_data (bus.BRAM_RDDATA),
      .rd_addr (cnt[L_RAM_SIZE-1:0]),
      .x_data  (x_rd),
      .acc_clr (acc_clr),
      .acc_en  (acc_en),
      .acc     (acc_all[g])
    );
  end

  always_comb begin
    acc_sel = '0;
    for (int r = 0; r < NUM_PE; r++) begin
      if (cnt == CW'(r)) begin
        acc_sel = acc_all[r];
      end
    end
  end

  always_comb begin
    word_idx = '0;
    case (state)
      S_LOAD_X: if (cnt != X_LAST) word_idx = x_base() + 32'(cnt);
      S_LOAD_W: if (cnt != W_LAST) word_idx = w_base(VECTOR_SIZE, 0) + 32'(cnt);
      S_WRITE:  word_idx = y_base(VECTOR_SIZE, NUM_PE) + 32'(cnt);
      default:  word_idx = '0;
    endcase
  end

  assign bus.BRAM_ADDR   = word_idx << 2;
  assign bus.BRAM_WE     = (state == S_WRITE) ? WE_ALL : 4'h0;
  assign bus.BRAM_WRDATA = (state != S_WRITE) ? '0 :
                           (relu_q && acc_sel[DATA_W-1]) ? '0 : acc_sel;
  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = (state == S_DONE);

endmodule

// File: tb/tb_mv_pe_con.sv
// tb/tb_mv_pe_con.sv - directed scoreboard bench for mv_pe_con with VECTOR_SIZE=4, NUM_PE=2
module tb_mv_pe_con;

  localparam int V = 4;
  localparam int N = 2;
  localparam int L = 2;

  logic aclk = 1'b0;
  logic areset = 1'b1;

  mv_pe_con_if bif ();

  mv_pe_con #(
    .VECTOR_SIZE (V),
    .L_RAM_SIZE  (L),
    .NUM_PE      (N)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bif)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] mem [16];
  int          n_assert = 0;
  int          n_fail = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  bit          mon_en = 1'b0;

  always @(posedge aclk) begin
    bif.BRAM_RDDATA <= mem[bif.BRAM_ADDR[5:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  always @(negedge aclk) begin
    if (mon_en) begin
      if (bif.done === 1'b1) done_cnt++;
      if (bif.BRAM_WE !== 4'h0) begin
        wr_t e;
        wr_cnt++;
        check("wr_we", 32'(bif.BRAM_WE), 32'hF);
        if (exp_q.size() == 0) begin
          check("wr_spurious_q_empty", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", bif.BRAM_ADDR, e.addr);
          check("wr_data", bif.BRAM_WRDATA, e.data);
        end
      end
    end
  end

  task automatic load_mem(input int xv[4], input int w0[4], input int w1[4]);
    for (int k = 0; k < V; k++) begin
      mem[k]       = xv[k];
      mem[V + k]   = w0[k];
      mem[2*V + k] = w1[k];
    end
  endtask

  function automatic logic [31:0] model(input int xv[4], input int w[4], input bit relu);
    int acc = 0;
    for (int k = 0; k < V; k++) acc += w[k] * xv[k];
    return (relu && acc < 0) ? 32'd0 : acc;
  endfunction

  task automatic push_exp(input logic [31:0] y0, input logic [31:0] y1);
    exp_q.push_back('{addr: 32'h30, data: y0});
    exp_q.push_back('{addr: 32'h34, data: y1});
  endtask

  task automatic run_job(input bit relu, input string tag);
    int cyc;
    @(negedge aclk);
    bif.relu_en = relu;
    bif.start   = 1'b1;
    @(posedge aclk);
    #1;
    bif.start   = 1'b0;
    bif.relu_en = 1'b0;
    cyc = 1;
    @(negedge aclk);
    check({tag, "_busy"}, 32'(bif.busy), 32'd1);
    for (int i = 0; i < 200; i++) begin
      if (bif.done === 1'b1) break;
      @(negedge aclk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd22);
    @(negedge aclk);
    check({tag, "_done_pulse"}, 32'(bif.done), 32'd0);
    check({tag, "_idle"}, 32'(bif.busy), 32'd0);
    check({tag, "_all_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int xv[4], w0[4], w1[4];
    int d0, w0c, nd, c1, gap, cyc;
    bit r;

    bif.start   = 1'b0;
    bif.relu_en = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;

    repeat (3) @(negedge aclk);
    check("rst_busy",   32'(bif.busy), 32'd0);
    check("rst_done",   32'(bif.done), 32'd0);
    check("rst_we",     32'(bif.BRAM_WE), 32'd0);
    check("rst_addr",   bif.BRAM_ADDR, 32'd0);
    check("rst_wrdata", bif.BRAM_WRDATA, 32'd0);
    mon_en = 1'b1;
    areset = 1'b0;

    xv = '{1, 2, 3, 4};
    w0 = '{1, 1, 1, 1};
    w1 = '{-1, 0, 0, -1};
    load_mem(xv, w0, w1);
    push_exp(32'd10, 32'hFFFF_FFFB);
    run_job(1'b0, "basic");

    push_exp(32'd10, 32'd0);
    run_job(1'b1, "relu");

    xv = '{32'h7FFF_FFFF, 1, 0, 0};
    w0 = '{1, 1, 0, 0};
    w1 = '{0, 0, 0, 0};
    load_mem(xv, w0, w1);
    push_exp(32'h8000_0000, 32'd0);
    run_job(1'b0, "wrap");

    for (int k = 0; k < V; k++) begin
      xv[k] = $urandom;
      w0[k] = int'($urandom_range(0, 2000)) - 1000;
      w1[k] = $urandom;
    end
    r = 1'($urandom_range(0, 1));
    load_mem(xv, w0, w1);
    push_exp(model(xv, w0, r), model(xv, w1, r));
    run_job(r, "random");

    xv = '{1, 2, 3, 4};
    w0 = '{1, 1, 1, 1};
    w1 = '{-1, 0, 0, -1};
    load_mem(xv, w0, w1);
    w0c = wr_cnt;
    d0  = done_cnt;
    @(negedge aclk);
    bif.start = 1'b1;
    @(posedge aclk);
    #1;
    bif.start = 1'b0;
    repeat (8) @(negedge aclk);
    check("midrst_busy_before", 32'(bif.busy), 32'd1);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    check("midrst_busy",   32'(bif.busy), 32'd0);
    check("midrst_we",     32'(bif.BRAM_WE), 32'd0);
    check("midrst_addr",   bif.BRAM_ADDR, 32'd0);
    check("midrst_done",   32'(bif.done), 32'd0);
    check("midrst_wrdata", bif.BRAM_WRDATA, 32'd0);
    repeat (40) @(negedge aclk);
    check("midrst_no_done",   32'(done_cnt), 32'(d0));
    check("midrst_no_writes", 32'(wr_cnt), 32'(w0c));

    push_exp(32'd10, 32'hFFFF_FFFB);
    run_job(1'b0, "after_rst");

    push_exp(32'd10, 32'hFFFF_FFFB);
    push_exp(32'd10, 32'hFFFF_FFFB);
    w0c = wr_cnt;
    nd  = 0;
    c1  = 0;
    gap = 0;
    cyc = 0;
    @(negedge aclk);
    bif.start = 1'b1;
    for (int i = 0; i < 300 && nd < 2; i++) begin
      @(negedge aclk);
      cyc++;
      if (bif.done === 1'b1) begin
        nd++;
        if (nd == 1) begin
          c1 = cyc;
        end else begin
          gap = cyc - c1;
          bif.start = 1'b0;
        end
      end
    end
    bif.start = 1'b0;
    repeat (5) @(negedge aclk);
    check("held_done_count", 32'(nd), 32'd2);
    check("held_job_gap",    32'(gap), 32'd23);
    check("held_idle",       32'(bif.busy), 32'd0);
    check("held_write_count", 32'(wr_cnt - w0c), 32'd4);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
